// File: rtl/de3cd_multichip_sync_n_if.sv
// Bus bundle between the TCD1304 timing front-end and the multichip ADS8556 sync block.
interface de3cd_multichip_sync_n_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PHASE_W = 4
);
  logic                        clk_2m;
  logic                        tcd1304_sh;
  logic                        tcd1304_load;
  logic [NUM_CH*PHASE_W-1:0]   sync_phase;
  logic                        sync_mode;
  logic [NUM_CH-1:0]           ads8556_syncn;
  logic                        sync_busy;
  logic                        sync_done;

  // Timing front-end side: drives frame events and phase settings.
  modport master (
    output clk_2m, tcd1304_sh, tcd1304_load, sync_phase, sync_mode,
    input  ads8556_syncn, sync_busy, sync_done
  );

  // Sync block side.
  modport slave (
    input  clk_2m, tcd1304_sh, tcd1304_load, sync_phase, sync_mode,
    output ads8556_syncn, sync_busy, sync_done
  );
endinterface

// File: rtl/de3cd_multichip_sync_n.sv
// Aligns the SYNC_N inputs of several ADS8556 chips to the TCD1304 shift-gate frame.
// Each channel drops its active-low sync a programmable number of clk_2m rising
// edges after the arming SH falling edge.
module de3cd_multichip_sync_n #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PHASE_W = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  de3cd_multichip_sync_n_if.slave bus
);

  logic                sh_q;
  logic                c2m_q;
  logic                sh_rise;
  logic                sh_fall;
  logic                c2m_rise;

  logic [PHASE_W-1:0]  phase_val [NUM_CH];
  logic [PHASE_W-1:0]  cnt       [NUM_CH];
  logic [PHASE_W-1:0]  cnt_nxt   [NUM_CH];
  logic                mode_r;
  logic                pending;
  logic                protect;
  logic                armed;
  logic                hold;
  logic [NUM_CH-1:0]   syncn_q;
  logic                busy_q;
  logic                done_q;

  logic                pending_nxt;
  logic                protect_nxt;
  logic                armed_nxt;
  logic                hold_nxt;
  logic [NUM_CH-1:0]   syncn_nxt;
  logic                arm_evt;
  logic                rep_rise;
  logic                rep_fall;

  // Single-stage edge detection against the previous sampled value.
  assign sh_rise  = bus.tcd1304_sh & ~sh_q;
  assign sh_fall  = ~bus.tcd1304_sh & sh_q;
  assign c2m_rise = bus.clk_2m & ~c2m_q;

  // Arming needs a full SH pulse seen while pending; a same-cycle load suppresses it.
  assign arm_evt  = sh_fall & pending & protect & ~bus.tcd1304_load;
  assign rep_rise = mode_r & armed & ~pending & sh_rise;
  assign rep_fall = mode_r & armed & ~pending & sh_fall;

  // Next-state for control flags, phase counters and sync outputs.
  always_comb begin
    pending_nxt = pending;
    protect_nxt = protect;
    armed_nxt   = armed;
    hold_nxt    = hold;
    syncn_nxt   = syncn_q;
    cnt_nxt     = cnt;

    if (bus.tcd1304_load) begin
      pending_nxt = 1'b1;
      protect_nxt = 1'b0;
    end else if (sh_rise && pending) begin
      protect_nxt = 1'b1;
    end

    if (arm_evt) begin
      pending_nxt = 1'b0;
      armed_nxt   = 1'b1;
    end

    // In repeat mode the outputs are parked high between SH rise and SH fall.
    if (sh_fall) begin
      hold_nxt = 1'b0;
    end else if (rep_rise) begin
      hold_nxt = 1'b1;
    end

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (arm_evt || rep_fall) begin
        cnt_nxt[k] = '0;
      end else if (armed && c2m_rise && (cnt[k] < phase_val[k])) begin
        cnt_nxt[k] = cnt[k] + PHASE_W'(1);
      end
      if (armed && !pending && !hold && (cnt[k] == phase_val[k])) begin
        syncn_nxt[k] = 1'b0;
      end
    end

    if ((sh_rise && pending) || rep_rise) begin
      syncn_nxt = '1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    sh_q  <= bus.tcd1304_sh;
    c2m_q <= bus.clk_2m;
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        phase_val[k] <= '0;
        cnt[k]       <= '0;
      end
      mode_r  <= 1'b0;
      pending <= 1'b1;
      protect <= 1'b0;
      armed   <= 1'b0;
      hold    <= 1'b0;
      syncn_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (bus.tcd1304_load) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          phase_val[k] <= bus.sync_phase[k*PHASE_W +: PHASE_W];
        end
        mode_r <= bus.sync_mode;
      end
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      protect <= protect_nxt;
      armed   <= armed_nxt;
      hold    <= hold_nxt;
      syncn_q <= syncn_nxt;
      busy_q  <= armed_nxt & ~pending_nxt & (|syncn_nxt);
      done_q  <= (|syncn_q) & ~(|syncn_nxt);
    end
  end

  assign bus.ads8556_syncn = syncn_q;
  assign bus.sync_busy     = busy_q;
  assign bus.sync_done     = done_q;

endmodule

// File: tb/tb_de3cd_multichip_sync_n.sv
// Self-checking bench for de3cd_multichip_sync_n: directed scenarios plus a
// randomized run compared every cycle against an edge-counting reference model.
module tb_de3cd_multichip_sync_n;
  localparam int unsigned NC = 4;
  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  de3cd_multichip_sync_n_if #(.NUM_CH(NC), .PHASE_W(PW)) bus ();
  de3cd_multichip_sync_n_if #(.NUM_CH(1),  .PHASE_W(2))  bus1 ();

  de3cd_multichip_sync_n #(.NUM_CH(NC), .PHASE_W(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  de3cd_multichip_sync_n #(.NUM_CH(1), .PHASE_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_tick  = 0;
  int done_cnt  = 0;
  int done1_cnt = 0;

  // Current stimulus levels
  bit                  cur_sh  = 1'b0;
  bit                  cur_c2m = 1'b0;
  bit                  cur_md  = 1'b0;
  logic [NC*PW-1:0]    cur_ph  = '0;
  logic [1:0]          cur_ph1 = '0;

  // Reference model: alignment tracked as "c2m edges seen since arming"
  bit           m_pend, m_prot, m_arm, m_mode, m_gate;
  int           m_edges;
  int           m_ph [NC];
  logic [NC-1:0] m_syncn;
  bit           m_done, m_busy;
  bit           psh, pc2m;

  task automatic model_step(input bit ld);
    bit rise, fall, crise, rep_rise, rep_fall, arm_now;
    logic [NC-1:0] ns;
    if (!rst_n) begin
      m_pend = 1'b1; m_prot = 1'b0; m_arm = 1'b0; m_mode = 1'b0; m_gate = 1'b0;
      m_edges = 0;
      for (int k = 0; k < NC; k++) m_ph[k] = 0;
      m_syncn = '1; m_done = 1'b0; m_busy = 1'b0;
      psh = cur_sh; pc2m = cur_c2m;
      return;
    end
    rise  = cur_sh && !psh;
    fall  = !cur_sh && psh;
    crise = cur_c2m && !pc2m;
    rep_rise = m_mode && m_arm && !m_pend && rise;
    rep_fall = m_mode && m_arm && !m_pend && fall;
    arm_now  = fall && m_pend && m_prot && !ld;

    ns = m_syncn;
    for (int k = 0; k < NC; k++)
      if (m_arm && !m_pend && !m_gate && m_edges >= m_ph[k]) ns[k] = 1'b0;
    if ((rise && m_pend) || rep_rise) ns = '1;
    m_done = (m_syncn != 0) && (ns == 0);

    if (ld) begin
      m_pend = 1'b1; m_prot = 1'b0; m_mode = cur_md;
      for (int k = 0; k < NC; k++) m_ph[k] = int'(cur_ph[k*PW +: PW]);
    end else if (rise && m_pend) begin
      m_prot = 1'b1;
    end
    if (arm_now) begin
      m_pend = 1'b0; m_arm = 1'b1; m_edges = 0; m_gate = 1'b0;
    end else if (rep_fall) begin
      m_edges = 0; m_gate = 1'b0;
    end else if (m_arm && crise) begin
      m_edges++;
    end
    if (rep_rise) m_gate = 1'b1;

    m_syncn = ns;
    m_busy  = m_arm && !m_pend && (ns != 0);
    psh = cur_sh; pc2m = cur_c2m;
  endtask

  // One clk: apply inputs, advance model, sample after the edge and compare.
  task automatic tick(input bit ld);
    bus.tcd1304_sh   = cur_sh;
    bus.clk_2m       = cur_c2m;
    bus.tcd1304_load = ld;
    bus.sync_phase   = cur_ph;
    bus.sync_mode    = cur_md;
    bus1.tcd1304_sh   = cur_sh;
    bus1.clk_2m       = cur_c2m;
    bus1.tcd1304_load = ld;
    bus1.sync_phase   = cur_ph1;
    bus1.sync_mode    = cur_md;
    model_step(ld);
    @(posedge clk);
    #1;
    n_tick++;
    n_tests += 3;
    if (bus.ads8556_syncn !== m_syncn) begin
      n_fail++;
      $display("FAIL model_syncn tick %0d got %b exp %b", n_tick, bus.ads8556_syncn, m_syncn);
    end
    if (bus.sync_busy !== m_busy) begin
      n_fail++;
      $display("FAIL model_busy tick %0d got %b exp %b", n_tick, bus.sync_busy, m_busy);
    end
    if (bus.sync_done !== m_done) begin
      n_fail++;
      $display("FAIL model_done tick %0d got %b exp %b", n_tick, bus.sync_done, m_done);
    end
    if (bus.sync_done === 1'b1) done_cnt++;
    if (bus1.sync_done === 1'b1) done1_cnt++;
  endtask

  task automatic c2m_pulse();
    cur_c2m = 1'b1; tick(1'b0);
    cur_c2m = 1'b0; tick(1'b0);
  endtask

  // SH high for w clks; the final tick is the falling-edge cycle.
  task automatic sh_pulse(input int w);
    cur_sh = 1'b1;
    repeat (w) tick(1'b0);
    cur_sh = 1'b0;
    tick(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'b0);
    n_tests += 4;
    if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL reset_syncn got %b exp 1111", bus.ads8556_syncn); end
    if (bus.sync_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.sync_busy); end
    if (bus.sync_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.sync_done); end
    if (bus1.ads8556_syncn !== 1'b1) begin n_fail++; $display("FAIL reset_syncn1 got %b exp 1", bus1.ads8556_syncn); end
    rst_n = 1'b1;
    repeat (2) tick(1'b0);
  endtask

  task automatic test_oneshot();
    int d0;
    logic [3:0] e;
    cur_md = 1'b0;
    cur_ph = {4'd3, 4'd2, 4'd1, 4'd0};
    tick(1'b1);
    d0 = done_cnt;
    sh_pulse(3);
    tick(1'b0);
    n_tests++;
    if (bus.ads8556_syncn !== 4'b1110) begin n_fail++; $display("FAIL oneshot_ph0 got %b exp 1110", bus.ads8556_syncn); end
    for (int k = 1; k <= 3; k++) begin
      c2m_pulse();
      e = 4'hF;
      e = 4'(e << (k + 1));
      n_tests++;
      if (bus.ads8556_syncn !== e) begin n_fail++; $display("FAIL oneshot_ph%0d got %b exp %b", k, bus.ads8556_syncn, e); end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL oneshot_done got %0d exp 1", done_cnt - d0); end
    sh_pulse(2);
    c2m_pulse(); c2m_pulse();
    n_tests += 2;
    if (bus.ads8556_syncn !== 4'b0000) begin n_fail++; $display("FAIL oneshot_hold got %b exp 0000", bus.ads8556_syncn); end
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL oneshot_nodone got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_repeat();
    int d0;
    cur_md = 1'b1;
    cur_ph = {4'd1, 4'd0, 4'd2, 4'd2};
    tick(1'b1);
    d0 = done_cnt;
    for (int p = 0; p < 3; p++) begin
      cur_sh = 1'b1;
      tick(1'b0);
      n_tests++;
      if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL repeat_rise%0d got %b exp 1111", p, bus.ads8556_syncn); end
      tick(1'b0);
      cur_sh = 1'b0;
      tick(1'b0);
      tick(1'b0);
      n_tests += 2;
      if (bus.ads8556_syncn !== 4'b1011) begin n_fail++; $display("FAIL repeat_e0_%0d got %b exp 1011", p, bus.ads8556_syncn); end
      if (bus.sync_busy !== 1'b1) begin n_fail++; $display("FAIL repeat_busy%0d got %b exp 1", p, bus.sync_busy); end
      c2m_pulse();
      n_tests++;
      if (bus.ads8556_syncn !== 4'b0011) begin n_fail++; $display("FAIL repeat_e1_%0d got %b exp 0011", p, bus.ads8556_syncn); end
      c2m_pulse();
      n_tests++;
      if (bus.ads8556_syncn !== 4'b0000) begin n_fail++; $display("FAIL repeat_e2_%0d got %b exp 0000", p, bus.ads8556_syncn); end
    end
    n_tests++;
    if (done_cnt - d0 != 3) begin n_fail++; $display("FAIL repeat_done got %0d exp 3", done_cnt - d0); end
  endtask

  task automatic test_load_in_sh();
    cur_md = 1'b0;
    cur_ph = '0;
    cur_sh = 1'b1;
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    cur_sh = 1'b0;
    tick(1'b0);
    c2m_pulse(); c2m_pulse();
    n_tests += 2;
    if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL loadsh_noarm got %b exp 1111", bus.ads8556_syncn); end
    if (bus.sync_busy !== 1'b0) begin n_fail++; $display("FAIL loadsh_busy got %b exp 0", bus.sync_busy); end
    sh_pulse(2);
    tick(1'b0);
    n_tests++;
    if (bus.ads8556_syncn !== 4'b0000) begin n_fail++; $display("FAIL loadsh_arm got %b exp 0000", bus.ads8556_syncn); end
  endtask

  task automatic test_load_on_fall();
    cur_md = 1'b0;
    cur_ph = 16'h0001;
    tick(1'b1);
    cur_sh = 1'b1;
    tick(1'b0); tick(1'b0);
    cur_sh = 1'b0;
    tick(1'b1);
    c2m_pulse(); c2m_pulse();
    n_tests += 2;
    if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL loadfall_noarm got %b exp 1111", bus.ads8556_syncn); end
    if (bus.sync_busy !== 1'b0) begin n_fail++; $display("FAIL loadfall_busy got %b exp 0", bus.sync_busy); end
    sh_pulse(2);
    tick(1'b0);
    n_tests++;
    if (bus.ads8556_syncn !== 4'b0001) begin n_fail++; $display("FAIL loadfall_e0 got %b exp 0001", bus.ads8556_syncn); end
    c2m_pulse();
    n_tests++;
    if (bus.ads8556_syncn !== 4'b0000) begin n_fail++; $display("FAIL loadfall_e1 got %b exp 0000", bus.ads8556_syncn); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    cur_md = 1'b0;
    cur_ph = '1;
    tick(1'b1);
    sh_pulse(2);
    repeat (7) c2m_pulse();
    n_tests += 2;
    if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL rstmid_pre got %b exp 1111", bus.ads8556_syncn); end
    if (bus.sync_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got %b exp 1", bus.sync_busy); end
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
    n_tests += 2;
    if (bus.ads8556_syncn !== 4'hF) begin n_fail++; $display("FAIL rstmid_syncn got %b exp 1111", bus.ads8556_syncn); end
    if (bus.sync_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy0 got %b exp 0", bus.sync_busy); end
    for (int i = 0; i < 10; i++) begin
      c2m_pulse();
      if (bus.ads8556_syncn !== 4'hF) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d changed cycles exp 0", bad); end
    cur_ph = '0;
    tick(1'b1);
    sh_pulse(2);
    tick(1'b0);
    n_tests++;
    if (bus.ads8556_syncn !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rearm got %b exp 0000", bus.ads8556_syncn); end
  endtask

  task automatic test_single_chip();
    int d0;
    cur_md  = 1'b0;
    cur_ph1 = 2'd3;
    tick(1'b1);
    d0 = done1_cnt;
    sh_pulse(2);
    tick(1'b0);
    n_tests++;
    if (bus1.ads8556_syncn !== 1'b1) begin n_fail++; $display("FAIL single_e0 got %b exp 1", bus1.ads8556_syncn); end
    for (int i = 1; i <= 3; i++) begin
      c2m_pulse();
      n_tests++;
      if (bus1.ads8556_syncn !== ((i < 3) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL single_e%0d got %b exp %b", i, bus1.ads8556_syncn, (i < 3) ? 1'b1 : 1'b0);
      end
    end
    n_tests++;
    if (done1_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done got %0d exp 1", done1_cnt - d0); end
  endtask

  task automatic test_random();
    bit ld;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) cur_sh = ~cur_sh;
      if ($urandom_range(0, 2) == 0) cur_c2m = ~cur_c2m;
      ld = ($urandom_range(0, 59) == 0);
      if (ld) begin
        for (int k = 0; k < NC; k++) cur_ph[k*PW +: PW] = 4'($urandom_range(0, 5));
        cur_md = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 699) != 0);
      tick(ld);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_oneshot();
    test_repeat();
    test_load_in_sh();
    test_load_on_fall();
    test_reset_mid();
    test_single_chip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/de3cd_multichip_sync_n.md
DE3CD_MULTICHIP_SYNC_N -- requirements
Module: de3cd_multichip_sync_n

Interface
REQ-001 Parameter NUM_CH, default 4: number of ADS8556 chips driven, legal range 1..8.
REQ-002 Parameter PHASE_W, default 4: width of each per-channel phase value.
REQ-003 clk  in  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 clk_2m  in  1  2 MHz conversion clock, sampled by clk; its rising edges are the phase-count events.
REQ-006 tcd1304_sh  in  1  TCD1304 shift-gate pulse, sampled by clk.
REQ-007 tcd1304_load  in  1  single-cycle strobe that captures sync_phase and sync_mode.
REQ-008 sync_phase  in  NUM_CH*PHASE_W  per-channel phase; channel k uses bits [k*PHASE_W +: PHASE_W].
REQ-009 sync_mode  in  1  0 = one-shot: sync is held after the first armed frame; 1 = repeat: resync on every SH frame.
REQ-010 ads8556_syncn  out  NUM_CH  per-channel active-low sync outputs.
REQ-011 sync_busy  out  1  high while any armed channel is high and still counting.
REQ-012 sync_done  out  1  one-clk pulse on the cycle the last armed channel drives its syncn low.

Function
REQ-013 Edge detection uses one register stage per input: sh_rise = prev 0 and now 1; sh_fall = prev 1 and now 0; c2m_rise = prev 0 and now 1.
REQ-014 tcd1304_load copies sync_phase and sync_mode into active registers (phase_val[k], mode_r) in the same cycle.
REQ-015 tcd1304_load sets the pending flag and clears the protect flag.
REQ-016 The protect flag sets on sh_rise while pending, so a load inside an SH-high window is applied on the next full SH pulse, never the current one.
REQ-017 On sh_rise while pending, all syncn go high.
REQ-018 On sh_fall while pending and protect are both set:
- pending clears;
- armed sets;
- all phase counters clear to 0.
REQ-019 In repeat mode while armed and not pending:
- every sh_rise drives all syncn high;
- every sh_fall clears all counters, starting a new alignment.
REQ-020 While armed, each channel counter increments on c2m_rise and saturates at phase_val[k]; it does not wrap.
REQ-021 Channel k drives syncn[k] low on the clk after (cnt[k] == phase_val[k]) with armed set and pending clear. Phase 0 therefore goes low 1 clk after the arming sh_fall.
REQ-022 In one-shot mode, syncn[k] stays low after assertion until the next load followed by sh_rise, or until reset.
REQ-023 sync_busy = armed AND pending clear AND any syncn[k] still high.
REQ-024 sync_done pulses exactly once per alignment, on the cycle the final syncn bit falls; channels already low do not retrigger it.
REQ-025 Simultaneous events:
- load in the same cycle as sh_fall: load wins and no arming occurs in that cycle;
- c2m_rise in the same cycle as the counter-clearing sh_fall: the clear wins.
REQ-026 A load while armed does not change any output until the REQ-017 sh_rise; the old alignment persists in the meantime.
REQ-027 Counters are PHASE_W bits, so the maximum phase is 2^PHASE_W-1 clk_2m edges. Values are unsigned and have no overflow path.

Reset
REQ-028 rst_n low at a clk edge sets:
- ads8556_syncn = all ones;
- sync_busy = 0 and sync_done = 0;
- counters = 0, phase_val = 0, mode_r = 0;
- pending = 1, protect = 0, armed = 0.
REQ-029 Edge-detect registers load the current input value during reset, so no spurious edge is seen on the first cycle after reset.
REQ-030 Reset mid-count aborts the alignment. After release, outputs stay high until the REQ-016/018 sequence completes.

Verification
REQ-031 NUM_CH=4, phases {0,1,2,3}, mode 0:
- stimulus: load, then one SH pulse;
- response: syncn[0] low 1 clk after sh_fall, syncn[k] low 1 clk after the k-th c2m_rise;
- sync_done pulses once, with syncn[3];
- later SH pulses leave all outputs low.
REQ-032 Mode 1, phases {2,2,0,1}:
- stimulus: three SH pulses;
- response: all syncn go high on each sh_rise and realign after each sh_fall with the same edge offsets;
- sync_done pulses three times.
REQ-033 Load asserted while SH is high:
- response: no arming at that SH fall;
- arming occurs at the following SH pulse's fall.
REQ-034 Load coincident with sh_fall:
- response: pending stays 1 and no counting starts;
- arming occurs at the next SH pulse.
REQ-035 Phase 15 with PHASE_W=4, then rst_n low after 7 c2m edges:
- response: all syncn = 1 immediately after reset;
- no output change until a new load and SH pulse.
REQ-036 NUM_CH=1, PHASE_W=2, phase 3, mode 0:
- response: behaviour matches a single-chip sync, with syncn low after 3 c2m edges following sh_fall.
